cam_capture_scaler: RTL and testbench
=====================================

# cam_capture_scaler

Parametrised camera capture front-end that replaces the fixed 160x120 RGB565-only capture path. It oversamples the camera bus (`Pclk`, `Href`, `Vsync`, `D`) in the system clock domain, assembles 2-byte pixels, converts them to RGB332 according to a run-time mode, decimates by a power of two, and emits write strobes, addresses and data for the frame-buffer dual-port RAM. It also flags each completed frame as good or bad.

## Interface
Parameters:
- `CAM_SCREEN_X`, 160: stored frame width in pixels, after decimation.
- `CAM_SCREEN_Y`, 120: stored frame height in pixels, after decimation.
- `AW`, 15: RAM address width; must satisfy 2^AW ≥ CAM_SCREEN_X*CAM_SCREEN_Y.
- `DW`, 8: RAM data width; fixed RGB332.
- `DEC_SHIFT`, 2: decimation factor DEC = 2^DEC_SHIFT, applied to both columns and rows. Legal values 0..2.

Ports:
- `clk`, in, 1: system clock. It is the only clock in the block.
- `rst`, in, 1: asynchronous reset, active-low.
- `mode`, in, 2: pixel format, sampled at frame start. 00 = RGB565, 01 = xRGB444, 10 = YUV422 gray (Y only), 11 = internal colour-bar test pattern.
- `Pclk`, in, 1: camera pixel clock. Asynchronous to `clk`.
- `Href`, in, 1: camera line valid. Asynchronous to `clk`.
- `Vsync`, in, 1: camera vertical sync, high during blanking. Asynchronous to `clk`.
- `D`, in, 8: camera data bus. Asynchronous to `clk`.
- `addr_out`, out, AW: RAM write address.
- `data_out`, out, DW: RAM write data in RGB332.
- `regwrite`, out, 1: RAM write strobe. One-cycle pulse.
- `busy`, out, 1: high while a frame is being captured.
- `frame_done`, out, 1: one-cycle pulse at the end of a complete, clean frame.
- `frame_err`, out, 1: one-cycle pulse at the end of a short or corrupted frame.

## Operation
- Input synchronisation: `Pclk`, `Href`, `Vsync` and `D` each pass through 2-FF synchronisers. A `Pclk` rising edge is detected as synced=1 while the previous synced value was 0. `Vsync` and `Href` edges are detected the same way.
- Pclk constraint: `Pclk` must stay high ≥2 `clk` periods and low ≥2 `clk` periods.
- State machine:
  - IDLE → FRAME on `Vsync` falling. On entry: col/row/write counters cleared, `mode` latched, `busy`=1.
  - FRAME → BYTE1 on a `Pclk` rising edge with `Href`=1. The block latches `D` as b0.
  - BYTE1 → FRAME on the next `Pclk` rising edge with `Href`=1. The block latches b1 and forms a pixel.
  - From FRAME or BYTE1 → IDLE on `Vsync` rising. On this transition `busy`=0 and the block pulses either `frame_done` or `frame_err`.
- Conversion to RGB332:
  - 00 (RGB565): {b0[7:5], b0[2:0], b1[4:3]}.
  - 01 (xRGB444): {b0[3:1], b1[7:5], b1[3:2]}.
  - 10 (gray): with Y=b0, {Y[7:5], Y[7:5], Y[7:6]}.
  - 11 (test pattern): ignores `D`. Bar index = (ocol*8)/CAM_SCREEN_X selects FF, FC, 1F, 1C, E3, E0, 03, 00 in that order. Frame timing is still driven by the camera signals.
- Input counters: `icol` counts formed pixels in the current line. `irow` counts lines and increments on `Href` falling. `icol` clears on `Href` falling.
- Decimation: output coordinates are ocol=icol>>DEC_SHIFT and orow=irow>>DEC_SHIFT.
- Write rule: a write happens only when all of these hold:
  - the low DEC_SHIFT bits of both `icol` and `irow` are 0;
  - ocol<CAM_SCREEN_X;
  - orow<CAM_SCREEN_Y.
  Pixels and lines outside these limits are dropped silently.
- Address: `addr_out` = orow*CAM_SCREEN_X + ocol. It never exceeds CAM_SCREEN_X*CAM_SCREEN_Y-1 and never wraps.
- Write counter: counts issued writes. `frame_done` requires count = CAM_SCREEN_X*CAM_SCREEN_Y and no line error; otherwise the frame ends with `frame_err`.
- Line error: `Href` falling while in BYTE1 (odd byte count). The block discards b0, returns to FRAME and sets an internal line-error flag. The flag clears at frame start.

## Timing
- Reset values: `addr_out`=0, `data_out`=0, `regwrite`=0, `busy`=0, `frame_done`=0, `frame_err`=0; state IDLE; all counters 0.
- Input latency: 2 `clk` cycles from a pad change to the synced value, plus 1 cycle for edge detection.
- Write latency: `regwrite`, `addr_out` and `data_out` are registered and valid in the same cycle, 1 `clk` after the cycle in which the b1 edge is detected. `addr_out` and `data_out` hold until the next write.
- Simultaneous events: `Vsync` rising in the same cycle as a b1 edge completes that pixel's write before the frame closes. The frame-status pulse follows one cycle later.
- Status pulse timing: `busy` falls in the same cycle as the `frame_done`/`frame_err` pulse.
- Reset mid-frame: the block returns to IDLE with no status pulse and waits for the next `Vsync` falling edge.
- `Vsync` rising while IDLE: ignored.

## Test plan
- Mode 00, DEC_SHIFT=0, full 160x120 frame of pixels (b0=F8, b1=00) → 19200 writes, each `data_out`=E0. Addresses run 0..19199 in order, then one `frame_done` pulse; `frame_err` stays 0.
- Mode 01, DEC_SHIFT=2, 640x480 input with b0=0F, b1=F0 → 19200 writes of FC. A write occurs only every 4th pixel of every 4th line; row 1 starts at address 160.
- Mode 10, gray ramp Y=col → `data_out` for pixel 0x80 is 92. Chroma bytes have no effect on the output.
- Mode 11 → bars at ocol 0, 20, 40, …, 140 produce FF, FC, 1F, 1C, E3, E0, 03, 00 respectively, regardless of `D`.
- Line with an odd byte count, or `Vsync` rising after 100 lines → `frame_err` pulse, no `frame_done`; the next clean frame gives `frame_done`.
- `rst` low mid-frame → all outputs return to 0 and `busy`=0 immediately. No writes occur until the next `Vsync` falling edge.

Source files
------------

// File: rtl/cam_capture_scaler.sv
// Camera capture front-end: oversamples the camera bus in the clk domain, assembles
// 2-byte pixels, converts them to RGB332, decimates by 2^DEC_SHIFT and issues RAM writes.
module cam_capture_scaler #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int DEC_SHIFT    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          Pclk,
  input  logic          Href,
  input  logic          Vsync,
  input  logic [7:0]    D,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  output logic          regwrite,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int FRAME_PIX = CAM_SCREEN_X * CAM_SCREEN_Y;
  // Counters are one bit wider than the largest useful input coordinate and saturate,
  // so oversized input frames can never wrap back into the stored window.
  localparam int CW = $clog2((CAM_SCREEN_X << DEC_SHIFT) + 1) + 1;
  localparam int RW = $clog2((CAM_SCREEN_Y << DEC_SHIFT) + 1) + 1;
  localparam int WW = $clog2(FRAME_PIX + 1);
  localparam int BW = CW + 3;
  localparam int SW = 11;
  localparam logic [CW-1:0] COL_MASK = CW'((1 << DEC_SHIFT) - 1);
  localparam logic [RW-1:0] ROW_MASK = RW'((1 << DEC_SHIFT) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_BYTE1, ST_CLOSE} state_t;

  logic [SW-1:0] pad_in;
  logic [SW-1:0] sync_vec;
  assign pad_in = {Vsync, Href, Pclk, D};

  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= pad_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_vec[gi] = s2_reg;
    end
  endgenerate

  logic       vsync_s, href_s, pclk_s;
  logic [7:0] d_s;
  assign {vsync_s, href_s, pclk_s, d_s} = sync_vec;

  logic pclk_d_reg, href_d_reg, vsync_d_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_d_reg  <= 1'b0;
      href_d_reg  <= 1'b0;
      vsync_d_reg <= 1'b0;
    end else begin
      pclk_d_reg  <= pclk_s;
      href_d_reg  <= href_s;
      vsync_d_reg <= vsync_s;
    end
  end

  logic byte_strobe, href_fall, vsync_fall, vsync_rise;
  assign byte_strobe = pclk_s & ~pclk_d_reg & href_s;
  assign href_fall   = ~href_s & href_d_reg;
  assign vsync_fall  = ~vsync_s & vsync_d_reg;
  assign vsync_rise  = vsync_s & ~vsync_d_reg;

  state_t          state_reg, state_next;
  logic [CW-1:0]   icol_reg, icol_next;
  logic [RW-1:0]   irow_reg, irow_next;
  logic [WW-1:0]   wcount_reg, wcount_next;
  logic            line_err_reg, line_err_next;
  logic [1:0]      mode_reg, mode_next;
  logic [7:0]      b0_reg, b0_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            regwrite_reg, regwrite_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  logic [CW-1:0] ocol;
  logic [RW-1:0] orow;
  logic          wr_ok;
  logic [AW-1:0] pix_addr;
  assign ocol     = icol_reg >> DEC_SHIFT;
  assign orow     = irow_reg >> DEC_SHIFT;
  assign wr_ok    = ((icol_reg & COL_MASK) == '0) && ((irow_reg & ROW_MASK) == '0) &&
                    (ocol < CW'(CAM_SCREEN_X)) && (orow < RW'(CAM_SCREEN_Y));
  assign pix_addr = AW'(orow) * AW'(CAM_SCREEN_X) + AW'(ocol);

  // Test-pattern bar index as a thermometer of ocol*8 >= k*CAM_SCREEN_X, avoiding a divider.
  logic [7:1] bar_ge;
  logic [2:0] bar_idx;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi] = {ocol, 3'b000} >= BW'(gi * CAM_SCREEN_X);
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) bar_idx = bar_idx + {2'b00, bar_ge[k]};
  end

  logic [7:0] bar_color;
  always_comb begin
    case (bar_idx)
      3'd0:    bar_color = 8'hFF;
      3'd1:    bar_color = 8'hFC;
      3'd2:    bar_color = 8'h1F;
      3'd3:    bar_color = 8'h1C;
      3'd4:    bar_color = 8'hE3;
      3'd5:    bar_color = 8'hE0;
      3'd6:    bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
  end

  // b1 is taken straight from the synced bus in the cycle its edge is detected.
  logic [7:0] pix_data;
  always_comb begin
    case (mode_reg)
      2'b00:   pix_data = {b0_reg[7:5], b0_reg[2:0], d_s[4:3]};
      2'b01:   pix_data = {b0_reg[3:1], d_s[7:5], d_s[3:2]};
      2'b10:   pix_data = {b0_reg[7:5], b0_reg[7:5], b0_reg[7:6]};
      default: pix_data = bar_color;
    endcase
  end

  logic unused_b0_bit;
  assign unused_b0_bit = b0_reg[4];

  always_comb begin
    state_next    = state_reg;
    icol_next     = icol_reg;
    irow_next     = irow_reg;
    wcount_next   = wcount_reg;
    line_err_next = line_err_reg;
    mode_next     = mode_reg;
    b0_next       = b0_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    regwrite_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vsync_fall) begin
          state_next    = ST_FRAME;
          icol_next     = '0;
          irow_next     = '0;
          wcount_next   = '0;
          line_err_next = 1'b0;
          mode_next     = mode;
          busy_next     = 1'b1;
        end
      end
      ST_FRAME, ST_BYTE1: begin
        if (href_fall) begin
          icol_next  = '0;
          irow_next  = (irow_reg == '1) ? irow_reg : irow_reg + RW'(1);
          state_next = ST_FRAME;
          if (state_reg == ST_BYTE1) line_err_next = 1'b1;
        end else if (byte_strobe) begin
          if (state_reg == ST_FRAME) begin
            b0_next    = d_s;
            state_next = ST_BYTE1;
          end else begin
            state_next = ST_FRAME;
            icol_next  = (icol_reg == '1) ? icol_reg : icol_reg + CW'(1);
            if (wr_ok) begin
              regwrite_next = 1'b1;
              addr_next     = pix_addr;
              data_next     = DW'(pix_data);
              wcount_next   = wcount_reg + WW'(1);
            end
          end
        end
        // Closing one cycle later lets a pixel completing with Vsync rising count first.
        if (vsync_rise) state_next = ST_CLOSE;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
        if (wcount_reg == WW'(FRAME_PIX) && !line_err_reg) done_next = 1'b1;
        else                                               err_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      icol_reg     <= '0;
      irow_reg     <= '0;
      wcount_reg   <= '0;
      line_err_reg <= 1'b0;
      mode_reg     <= 2'b00;
      b0_reg       <= 8'h00;
      addr_reg     <= '0;
      data_reg     <= '0;
      regwrite_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      icol_reg     <= icol_next;
      irow_reg     <= irow_next;
      wcount_reg   <= wcount_next;
      line_err_reg <= line_err_next;
      mode_reg     <= mode_next;
      b0_reg       <= b0_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      regwrite_reg <= regwrite_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign addr_out   = addr_reg;
  assign data_out   = data_reg;
  assign regwrite   = regwrite_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;
  assign frame_err  = err_reg;

endmodule

// File: tb/tb_cam_capture_scaler.sv
// Randomized bench for cam_capture_scaler: drives camera frames and compares every RAM
// write and frame status pulse against a coordinate-level reference model.
module tb_cam_capture_scaler;

  localparam int X   = 20;
  localparam int Y   = 6;
  localparam int DS  = 1;
  localparam int DEC = 1 << DS;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          Pclk = 1'b0;
  logic          Href = 1'b0;
  logic          Vsync = 1'b1;
  logic [7:0]    D = 8'h00;
  logic [AW-1:0] addr_out;
  logic [7:0]    data_out;
  logic          regwrite, busy, frame_done, frame_err;

  cam_capture_scaler #(
    .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW), .DW(8), .DEC_SHIFT(DS)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .Pclk(Pclk), .Href(Href), .Vsync(Vsync), .D(D),
    .addr_out(addr_out), .data_out(data_out), .regwrite(regwrite), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int frame_writes;
  bit expect_en = 1'b1;
  logic [1:0] cur_mode;
  int exp_addr_q[$];
  int exp_data_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] rgb332(input logic [1:0] m, input logic [7:0] b0,
                                        input logic [7:0] b1, input int ocol);
    logic [7:0] bars [8];
    bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    case (m)
      2'd0:    return {b0[7:5], b0[2:0], b1[4:3]};
      2'd1:    return {b0[3:1], b1[7:5], b1[3:2]};
      2'd2:    return {b0[7:5], b0[7:5], b0[7:6]};
      default: return bars[(ocol * 8) / X];
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (regwrite) begin
        if (exp_addr_q.size() == 0) check("spurious_write", 32'd1, 32'd0);
        else begin
          check("wr_addr", 32'(addr_out), exp_addr_q.pop_front());
          check("wr_data", 32'(data_out), exp_data_q.pop_front());
        end
      end
      if (frame_done || frame_err) check("busy_at_status", 32'(busy), 32'd0);
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] v, input bit vs_rise);
    @(negedge clk); Pclk = 1'b0; D = v;
    @(negedge clk);
    @(negedge clk); Pclk = 1'b1; if (vs_rise) Vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_line(input int r, input int npix, input bit odd, input bit vs_last);
    @(negedge clk); Href = 1'b1;
    for (int c = 0; c < npix; c++) begin
      logic [7:0] b0, b1;
      b0 = (cur_mode == 2'd2) ? 8'(c * 6) : 8'($urandom);
      b1 = 8'($urandom);
      send_byte(b0, 1'b0);
      send_byte(b1, vs_last && (c == npix - 1));
      if (expect_en && c % DEC == 0 && r % DEC == 0 && c / DEC < X && r / DEC < Y) begin
        exp_addr_q.push_back((r / DEC) * X + c / DEC);
        exp_data_q.push_back(32'(rgb332(cur_mode, b0, b1, c / DEC)));
        frame_writes++;
      end
    end
    if (odd) send_byte(8'($urandom), 1'b0);
    @(negedge clk); Pclk = 1'b0; Href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [1:0] m, input int nlines,
                           input int npix, input int odd_line, input bit vs_last);
    int d0, e0;
    bit clean;
    cur_mode = m; mode = m; frame_writes = 0;
    @(negedge clk); Vsync = 1'b1;
    repeat (4) @(negedge clk);
    Vsync = 1'b0;
    repeat (6) @(negedge clk);
    check({name, "_busy_start"}, 32'(busy), 32'd1);
    d0 = done_cnt; e0 = err_cnt;
    for (int r = 0; r < nlines; r++)
      drive_line(r, (vs_last && r == nlines - 1) ? npix - 1 : npix, r == odd_line,
                 vs_last && r == nlines - 1);
    Vsync = 1'b1;
    repeat (10) @(negedge clk);
    clean = (frame_writes == X * Y) && (odd_line < 0);
    check({name, "_done"}, 32'(done_cnt - d0), 32'(clean));
    check({name, "_err"}, 32'(err_cnt - e0), 32'(!clean));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    $display("frame %s mode=%0d lines=%0d writes=%0d clean=%0b", name, m, nlines,
             frame_writes, clean);
  endtask

  initial begin
    int d0, e0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_outs", {28'd0, regwrite, busy, frame_done, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    run_frame("rgb565", 2'd0, Y * DEC, X * DEC, -1, 1'b0);
    run_frame("xrgb444_oversize", 2'd1, Y * DEC + 2, X * DEC + 4, -1, 1'b0);
    run_frame("gray_ramp", 2'd2, Y * DEC, X * DEC, -1, 1'b0);
    run_frame("test_bars", 2'd3, Y * DEC, X * DEC, -1, 1'b0);
    run_frame("odd_line", 2'($urandom_range(0, 3)), Y * DEC, X * DEC, 3, 1'b0);
    run_frame("short_frame", 2'd0, 7, X * DEC, -1, 1'b0);
    run_frame("clean_after_err", 2'd1, Y * DEC, X * DEC, -1, 1'b0);
    run_frame("vsync_on_last_pixel", 2'($urandom_range(0, 3)), (Y - 1) * DEC + 1, X * DEC,
              -1, 1'b1);

    // Reset in the middle of a frame, then camera activity without a new frame start.
    cur_mode = 2'd0; mode = 2'd0; frame_writes = 0;
    @(negedge clk); Vsync = 1'b1;
    repeat (4) @(negedge clk);
    Vsync = 1'b0;
    repeat (6) @(negedge clk);
    drive_line(0, 10, 1'b0, 1'b0);
    @(negedge clk); Href = 1'b1;
    send_byte(8'($urandom), 1'b0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("midrst_addr", 32'(addr_out), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_outs", {28'd0, regwrite, busy, frame_done, frame_err}, 32'd0);
    check("midrst_pending", 32'(exp_addr_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    expect_en = 1'b0;
    drive_line(1, X * DEC, 1'b0, 1'b0);
    drive_line(2, X * DEC, 1'b0, 1'b0);
    Vsync = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_no_status", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);
    $display("frame reset_mid_frame mode=0 status_pulses=%0d", (done_cnt - d0) + (err_cnt - e0));
    expect_en = 1'b1;
    run_frame("after_reset", 2'd3, Y * DEC, X * DEC, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
